char_write_ctrl: RTL and testbench

// Sequences all writes into the char_buffer for the VT52 text display. It owns the

---
 rtl/char_write_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_char_write_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/char_write_ctrl.sv
// VT52 char_buffer write sequencer: owns the cursor, takes PUT/SET/CLEAR/NEWLINE requests,
// issues one-cycle buffer writes inside wr_win. Optional CLEAR_ON_WRAP_EN blanks each newly entered row.
module char_write_ctrl #(
  parameter int COLS   = 80,
  parameter int ROWS   = 24,
  parameter int ADDR_W = 11
) (
  input  logic              px_clk,
  input  logic              clr,
  input  logic              wr_win,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_cmd,
  input  logic [7:0]        req_char,
  input  logic [4:0]        req_row,
  input  logic [6:0]        req_col,
  output logic              buf_sel,
  output logic              buf_wen,
  output logic [ADDR_W-1:0] buf_waddr,
  output logic [7:0]        buf_din,
  output logic [4:0]        cur_row,
  output logic [6:0]        cur_col,
  output logic              busy
);

  localparam logic [1:0]        CMD_PUT = 2'd0;
  localparam logic [1:0]        CMD_SET = 2'd1;
  localparam logic [1:0]        CMD_CLR = 2'd2;
  localparam logic [1:0]        CMD_NL  = 2'd3;
  localparam logic [4:0]        ROW_MAX = 5'(ROWS - 1);
  localparam logic [6:0]        COL_MAX = 7'(COLS - 1);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(ROWS * COLS - 1);
  localparam logic [7:0]        BLANK   = 8'h20;

`ifdef CLEAR_ON_WRAP_EN
  typedef enum logic [1:0] {IDLE, PUT, CLRSCR, CLRLINE} state_t;
`else
  typedef enum logic [1:0] {IDLE, PUT, CLRSCR} state_t;
`endif

  state_t            state, state_n;
  logic [4:0]        row_n;
  logic [6:0]        col_n;
  logic [ADDR_W-1:0] cur_addr, addr_n, clr_ptr, ptr_n, waddr_n;
  logic [7:0]        char_q, char_n, din_n;
  logic              wen_n, sel_n;

  logic [4:0]        set_row, nl_row;
  logic [6:0]        set_col;
  logic [ADDR_W-1:0] set_addr, nl_addr;
  logic              at_col_end, at_row_end;

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign at_col_end = (cur_col == COL_MAX);
  assign at_row_end = (cur_row == ROW_MAX);
  assign set_row    = (req_row > ROW_MAX) ? ROW_MAX : req_row;
  assign set_col    = (req_col > COL_MAX) ? COL_MAX : req_col;
  // Start of the following row, derived from cur_addr without a multiply.
  assign nl_row     = at_row_end ? 5'd0 : cur_row + 5'd1;
  assign nl_addr    = at_row_end ? '0 : cur_addr - ADDR_W'(cur_col) + ADDR_W'(COLS);

  // row*COLS as a constant shift-add, only needed for absolute cursor moves.
  always_comb begin
    set_addr = ADDR_W'(set_col);
    for (int i = 0; i < 8; i++)
      if (COLS[i]) set_addr = set_addr + (ADDR_W'(set_row) << i);
  end

  always_comb begin
    state_n = state;
    row_n   = cur_row;
    col_n   = cur_col;
    addr_n  = cur_addr;
    char_n  = char_q;
    ptr_n   = clr_ptr;
    wen_n   = 1'b0;
    sel_n   = 1'b0;
    waddr_n = buf_waddr;
    din_n   = buf_din;
    case (state)
      IDLE: if (req_valid) begin
        case (req_cmd)
          CMD_PUT: begin
            char_n  = req_char;
            state_n = PUT;
          end
          CMD_SET: begin
            row_n  = set_row;
            col_n  = set_col;
            addr_n = set_addr;
          end
          CMD_CLR: begin
            ptr_n   = '0;
            state_n = CLRSCR;
          end
          default: begin
            row_n  = nl_row;
            col_n  = 7'd0;
            addr_n = nl_addr;
`ifdef CLEAR_ON_WRAP_EN
            ptr_n   = nl_addr;
            state_n = CLRLINE;
`endif
          end
        endcase
      end
      PUT: if (wr_win) begin
        wen_n   = 1'b1;
        sel_n   = 1'b1;
        waddr_n = cur_addr;
        din_n   = char_q;
        state_n = IDLE;
        if (!at_col_end) begin
          col_n  = cur_col + 7'd1;
          addr_n = cur_addr + 1'b1;
        end else begin
          col_n  = 7'd0;
          row_n  = nl_row;
          addr_n = nl_addr;
`ifdef CLEAR_ON_WRAP_EN
          ptr_n   = nl_addr;
          state_n = CLRLINE;
`endif
        end
      end
      CLRSCR: if (wr_win) begin
        wen_n   = 1'b1;
        sel_n   = 1'b1;
        waddr_n = clr_ptr;
        din_n   = BLANK;
        ptr_n   = clr_ptr + 1'b1;
        if (clr_ptr == LAST) begin
          row_n   = 5'd0;
          col_n   = 7'd0;
          addr_n  = '0;
          state_n = IDLE;
        end
      end
`ifdef CLEAR_ON_WRAP_EN
      CLRLINE: if (wr_win) begin
        wen_n   = 1'b1;
        sel_n   = 1'b1;
        waddr_n = clr_ptr;
        din_n   = BLANK;
        ptr_n   = clr_ptr + 1'b1;
        if (clr_ptr == cur_addr + ADDR_W'(COL_MAX)) state_n = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge px_clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      cur_row   <= '0;
      cur_col   <= '0;
      cur_addr  <= '0;
      char_q    <= '0;
      clr_ptr   <= '0;
      buf_wen   <= 1'b0;
      buf_sel   <= 1'b0;
      buf_waddr <= '0;
      buf_din   <= '0;
    end else begin
      state     <= state_n;
      cur_row   <= row_n;
      cur_col   <= col_n;
      cur_addr  <= addr_n;
      char_q    <= char_n;
      clr_ptr   <= ptr_n;
      buf_wen   <= wen_n;
      buf_sel   <= sel_n;
      buf_waddr <= waddr_n;
      buf_din   <= din_n;
    end
  end

endmodule

// File: tb/tb_char_write_ctrl.sv
// Directed bench for char_write_ctrl: cursor moves, PUT latency/wrap, wr_win stalls,
// full clear ordering, and async reset abort. Honours CLEAR_ON_WRAP_EN when defined.
module tb_char_write_ctrl;

`ifdef CLEAR_ON_WRAP_EN
  localparam int WRAP_W = 80;
`else
  localparam int WRAP_W = 0;
`endif

  logic        px_clk, clr, wr_win, req_valid, req_ready;
  logic [1:0]  req_cmd;
  logic [7:0]  req_char;
  logic [4:0]  req_row;
  logic [6:0]  req_col;
  logic        buf_sel, buf_wen, busy;
  logic [10:0] buf_waddr;
  logic [7:0]  buf_din;
  logic [4:0]  cur_row;
  logic [6:0]  cur_col;

  int n_chk = 0;
  int n_err = 0;
  logic [10:0] qa[$];
  logic [7:0]  qd[$];

  char_write_ctrl #(.COLS(80), .ROWS(24), .ADDR_W(11)) dut (
    .px_clk(px_clk), .clr(clr), .wr_win(wr_win),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_char(req_char), .req_row(req_row), .req_col(req_col),
    .buf_sel(buf_sel), .buf_wen(buf_wen), .buf_waddr(buf_waddr), .buf_din(buf_din),
    .cur_row(cur_row), .cur_col(cur_col), .busy(busy)
  );

  initial px_clk = 1'b0;
  always #5 px_clk = ~px_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Write monitor: records every buffer write, and sel must track wen.
  always @(negedge px_clk) begin
    if (buf_wen || buf_sel) begin
      chk("sel_eq_wen", {31'd0, buf_sel}, {31'd0, buf_wen});
      if (buf_wen) begin
        qa.push_back(buf_waddr);
        qd.push_back(buf_din);
      end
    end
  end

  task automatic send(input logic [1:0] cmd, input logic [7:0] ch,
                      input logic [4:0] row, input logic [6:0] col);
    int n;
    @(negedge px_clk);
    req_valid = 1'b1; req_cmd = cmd; req_char = ch; req_row = row; req_col = col;
    n = 0;
    while (!req_ready && n < 1000) begin
      @(negedge px_clk);
      n++;
    end
    chk("accept_timeout", {31'd0, req_ready}, 32'd1);
    @(posedge px_clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    @(negedge px_clk);
    while (busy && n < lim) begin
      @(negedge px_clk);
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
    @(negedge px_clk);
  endtask

  task automatic clrq();
    qa.delete();
    qd.delete();
  endtask

  initial begin
    int bad;
    clr = 1'b1; wr_win = 1'b1; req_valid = 1'b0;
    req_cmd = '0; req_char = '0; req_row = '0; req_col = '0;
    repeat (2) @(negedge px_clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_wen", {31'd0, buf_wen}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pos", {20'd0, cur_row, cur_col}, 32'd0);
    chk("rst_waddr", {21'd0, buf_waddr}, 32'd0);
    chk("rst_din", {24'd0, buf_din}, 32'd0);
    clr = 1'b0;

    // PUT 'A' at 0/0: no write one cycle after accept, write the next.
    clrq();
    send(2'd0, 8'h41, 0, 0);
    @(negedge px_clk);
    chk("put_lat_wen0", {31'd0, buf_wen}, 32'd0);
    chk("put_busy", {31'd0, busy}, 32'd1);
    @(negedge px_clk);
    chk("put_lat_wen1", {31'd0, buf_wen}, 32'd1);
    chk("put_waddr", {21'd0, buf_waddr}, 32'd0);
    chk("put_din", {24'd0, buf_din}, 32'h41);
    wait_idle(100);
    chk("put_count", qa.size(), 32'd1);
    chk("put_row", {27'd0, cur_row}, 32'd0);
    chk("put_col", {25'd0, cur_col}, 32'd1);

    // SET 3/79 then PUT -> addr 319, cursor 4/0.
    send(2'd1, 8'h00, 5'd3, 7'd79);
    @(negedge px_clk);
    chk("set_row", {27'd0, cur_row}, 32'd3);
    chk("set_col", {25'd0, cur_col}, 32'd79);
    clrq();
    send(2'd0, 8'h42, 0, 0);
    wait_idle(500);
    chk("wrap_count", qa.size(), 32'(1 + WRAP_W));
    chk("wrap_addr", {21'd0, qa[0]}, 32'd319);
    chk("wrap_din", {24'd0, qd[0]}, 32'h42);
    chk("wrap_row", {27'd0, cur_row}, 32'd4);
    chk("wrap_col", {25'd0, cur_col}, 32'd0);

    // SET clamps out-of-range coordinates.
    send(2'd1, 8'h00, 5'd31, 7'd100);
    @(negedge px_clk);
    chk("clamp_row", {27'd0, cur_row}, 32'd23);
    chk("clamp_col", {25'd0, cur_col}, 32'd79);

    // PUT at the last cell wraps to 0/0; next PUT lands at 0.
    clrq();
    send(2'd0, 8'h5A, 0, 0);
    wait_idle(500);
    chk("last_addr", {21'd0, qa[0]}, 32'd1919);
    chk("last_row", {27'd0, cur_row}, 32'd0);
    chk("last_col", {25'd0, cur_col}, 32'd0);
    clrq();
    send(2'd0, 8'h31, 0, 0);
    wait_idle(100);
    chk("home_addr", {21'd0, qa[0]}, 32'd0);

    // PUT held off by wr_win=0 for 50 cycles.
    clrq();
    wr_win = 1'b0;
    send(2'd0, 8'h32, 0, 0);
    bad = 0;
    repeat (50) begin
      @(negedge px_clk);
      if (buf_wen || req_ready) bad++;
    end
    chk("stall_quiet", bad, 32'd0);
    wr_win = 1'b1;
    wait_idle(100);
    chk("stall_count", qa.size(), 32'd1);
    chk("stall_addr", {21'd0, qa[0]}, 32'd1);
    chk("stall_col", {25'd0, cur_col}, 32'd2);

    // NEWLINE from row 5 lands on row 6 (blanked when CLEAR_ON_WRAP_EN).
    send(2'd1, 8'h00, 5'd5, 7'd10);
    clrq();
    send(2'd3, 8'h00, 0, 0);
    wait_idle(500);
    chk("nl_count", qa.size(), 32'(WRAP_W));
    bad = 0;
    for (int i = 0; i < qa.size(); i++)
      if (qa[i] != 11'(480 + i) || qd[i] != 8'h20) bad++;
    chk("nl_line", bad, 32'd0);
    chk("nl_row", {27'd0, cur_row}, 32'd6);
    chk("nl_col", {25'd0, cur_col}, 32'd0);
    clrq();
    send(2'd0, 8'h33, 0, 0);
    wait_idle(100);
    chk("nl_put_addr", {21'd0, qa[0]}, 32'd480);

    // CLEAR with wr_win toggling: 1920 blanks in address order, cursor home.
    clrq();
    send(2'd2, 8'h00, 0, 0);
    for (int n = 0; n < 20000; n++) begin
      @(negedge px_clk);
      wr_win = 1'($urandom_range(0, 1));
      if (!busy) break;
    end
    wr_win = 1'b1;
    chk("clr_done", {31'd0, busy}, 32'd0);
    @(negedge px_clk);
    chk("clr_count", qa.size(), 32'd1920);
    bad = 0;
    for (int i = 0; i < qa.size(); i++)
      if (qa[i] != 11'(i) || qd[i] != 8'h20) bad++;
    chk("clr_order", bad, 32'd0);
    chk("clr_pos", {20'd0, cur_row, cur_col}, 32'd0);

    // Async reset mid-clear aborts immediately.
    send(2'd1, 8'h00, 5'd7, 7'd7);
    send(2'd2, 8'h00, 0, 0);
    repeat (100) @(negedge px_clk);
    chk("abort_busy", {31'd0, busy}, 32'd1);
    clr = 1'b1;
    #1;
    chk("abort_wen", {31'd0, buf_wen}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_pos", {20'd0, cur_row, cur_col}, 32'd0);
    @(negedge px_clk);
    clr = 1'b0;
    clrq();
    send(2'd0, 8'h34, 0, 0);
    wait_idle(100);
    chk("post_rst_addr", {21'd0, qa[0]}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
